// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: fetch (port 0) and memory stage (port 1)
// share one memory interface; one transaction is in flight at a time.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_valid/addr/size/strobe/data   per-port request (index 0 = fetch, 1 = mem stage)
//   resp_data_ok, resp_data           per-port completion pulse and read data
//   mem_valid/addr/size/strobe/data   latched request toward memory
//   mem_data_ok, mem_rdata            memory completion and read data
//   grant                             owner index while BUSY
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to break ties by alternating
// against the last completed owner; otherwise port 1 always wins a tie.
module mem_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][2:0]        req_size,
    input  logic [1:0][STRB_W-1:0] req_strobe,
    input  logic [1:0][DATA_W-1:0] req_data,
    output logic [1:0]             resp_data_ok,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   mem_valid,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [2:0]             mem_size,
    output logic [STRB_W-1:0]      mem_strobe,
    output logic [DATA_W-1:0]      mem_data,
    input  logic                   mem_data_ok,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;

    state_t state;
    logic   win;
    logic   done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie the port that did not own the bus last time wins.
    always_comb begin
        win = req_valid[1];
        if (req_valid == 2'b11) begin
            win = ~last_grant;
        end
    end
`else
    // Fixed priority: the memory stage beats fetch.
    always_comb begin
        win = req_valid[1];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_valid  <= 1'b0;
            grant      <= 1'b0;
            mem_addr   <= '0;
            mem_size   <= '0;
            mem_strobe <= '0;
            mem_data   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state      <= BUSY;
                        mem_valid  <= 1'b1;
                        grant      <= win;
                        mem_addr   <= req_addr[win];
                        mem_size   <= req_size[win];
                        mem_strobe <= req_strobe[win];
                        mem_data   <= req_data[win];
                    end
                end
                BUSY: begin
                    // Request fields stay frozen until memory completes,
                    // even if the requester drops valid.
                    if (mem_data_ok) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

    // Completion is only forwarded while a transaction is in flight, so a
    // stale response after reset is dropped.
    assign done = mem_valid & mem_data_ok;

    always_comb begin
        resp_data_ok = 2'b00;
        resp_data    = '0;
        if (done) begin
            resp_data_ok = grant ? 2'b10 : 2'b01;
            resp_data    = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever resp_data_ok fires.
module tb_mem_bus_arbiter;

    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0][63:0] req_addr;
    logic [1:0][2:0]  req_size;
    logic [1:0][7:0]  req_strobe;
    logic [1:0][63:0] req_data;
    logic [1:0]       resp_data_ok;
    logic [63:0]      resp_data;
    logic             mem_valid;
    logic [63:0]      mem_addr;
    logic [2:0]       mem_size;
    logic [7:0]       mem_strobe;
    logic [63:0]      mem_data;
    logic             mem_data_ok;
    logic [63:0]      mem_rdata;
    logic             grant;

    typedef struct {
        logic [1:0]  mask;
        logic [63:0] rdata;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic        owner;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_strobe   (req_strobe),
        .req_data     (req_data),
        .resp_data_ok (resp_data_ok),
        .resp_data    (resp_data),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_size     (mem_size),
        .mem_strobe   (mem_strobe),
        .mem_data     (mem_data),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .grant        (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int p, input logic [63:0] rdata);
        exp_t x;
        x.mask   = (p == 1) ? 2'b10 : 2'b01;
        x.rdata  = rdata;
        x.addr   = req_addr[p];
        x.size   = req_size[p];
        x.strobe = req_strobe[p];
        x.wdata  = req_data[p];
        x.owner  = (p == 1);
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (resp_data_ok !== 2'b00) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got %b expected 00",
                         resp_data_ok);
            end else begin
                e = sb.pop_front();
                check("resp_data_ok", {62'd0, resp_data_ok}, {62'd0, e.mask});
                check("resp_data", resp_data, e.rdata);
                check("mem_addr@ok", mem_addr, e.addr);
                check("mem_size@ok", {61'd0, mem_size}, {61'd0, e.size});
                check("mem_strobe@ok", {56'd0, mem_strobe}, {56'd0, e.strobe});
                check("mem_data@ok", mem_data, e.wdata);
                check("grant@ok", {63'd0, grant}, {63'd0, e.owner});
            end
        end
    end

    logic seq_port;

    initial begin
        reset       = 1'b1;
        req_valid   = 2'b00;
        req_addr    = '0;
        req_size    = '0;
        req_strobe  = '0;
        req_data    = '0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        check("rst_resp_ok", {62'd0, resp_data_ok}, 64'd0);
        check("rst_grant", {63'd0, grant}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_data", mem_data, 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        reset = 1'b0;
        tick();

        // single fetch, data_ok two cycles after mem_valid, addr changed mid-flight
        req_addr[0]   = 64'h8000_0000;
        req_size[0]   = MSIZE4;
        req_strobe[0] = 8'h00;
        req_valid     = 2'b01;
        push_exp(0, 64'h1234);
        tick();
        check("fetch_mem_valid", {63'd0, mem_valid}, 64'd1);
        check("fetch_grant", {63'd0, grant}, 64'd0);
        check("fetch_strobe", {56'd0, mem_strobe}, 64'd0);
        check("fetch_size", {61'd0, mem_size}, {61'd0, MSIZE4});
        req_addr[0] = 64'hDEAD_0000;
        tick();
        check("stable_addr1", mem_addr, 64'h8000_0000);
        tick();
        check("stable_addr2", mem_addr, 64'h8000_0000);
        mem_data_ok = 1'b1;
        mem_rdata   = 64'h1234;
        req_valid   = 2'b00;
        tick();
        mem_data_ok = 1'b0;
        check("fetch_idle", {63'd0, mem_valid}, 64'd0);

        // single store, earliest completion
        req_addr[1]   = 64'h8000_0008;
        req_size[1]   = MSIZE8;
        req_strobe[1] = 8'hFF;
        req_data[1]   = 64'hDEAD_BEEF;
        req_valid     = 2'b10;
        push_exp(1, 64'h0);
        tick();
        check("store_mem_valid", {63'd0, mem_valid}, 64'd1);
        check("store_addr", mem_addr, 64'h8000_0008);
        check("store_size", {61'd0, mem_size}, {61'd0, MSIZE8});
        check("store_strobe", {56'd0, mem_strobe}, 64'hFF);
        check("store_data", mem_data, 64'hDEAD_BEEF);
        check("store_grant", {63'd0, grant}, 64'd1);
        mem_data_ok = 1'b1;
        mem_rdata   = 64'h0;
        req_valid   = 2'b00;
        tick();
        mem_data_ok = 1'b0;
        check("store_idle", {63'd0, mem_valid}, 64'd0);

        // reset while port 1 owns the bus; late response must be dropped
        req_addr[1] = 64'h8000_0010;
        req_valid   = 2'b10;
        tick();
        check("pre_rst_grant", {63'd0, grant}, 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_mem_valid", {63'd0, mem_valid}, 64'd0);
        check("midrst_grant", {63'd0, grant}, 64'd0);
        check("midrst_addr", mem_addr, 64'd0);
        req_valid = 2'b00;
        tick();
        reset       = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 64'hBAD;
        #1;
        check("stale_resp_ok", {62'd0, resp_data_ok}, 64'd0);
        tick();
        mem_data_ok = 1'b0;
        check("stale_idle", {63'd0, mem_valid}, 64'd0);

        // tie: port 1 first, IDLE in between, then port 0
        req_addr[0]   = 64'h8000_0100;
        req_size[0]   = MSIZE4;
        req_strobe[0] = 8'h00;
        req_data[0]   = 64'h0;
        req_addr[1]   = 64'h8000_0200;
        req_size[1]   = MSIZE8;
        req_strobe[1] = 8'hF0;
        req_data[1]   = 64'h1111_2222;
        req_valid     = 2'b11;
        push_exp(1, 64'hAAAA);
        push_exp(0, 64'h5555);
        tick();
        check("tie_first_grant", {63'd0, grant}, 64'd1);
        mem_data_ok = 1'b1;
        mem_rdata   = 64'hAAAA;
        req_valid   = 2'b01;
        tick();
        mem_data_ok = 1'b0;
        check("tie_idle_between", {63'd0, mem_valid}, 64'd0);
        tick();
        check("tie_second_valid", {63'd0, mem_valid}, 64'd1);
        check("tie_second_grant", {63'd0, grant}, 64'd0);
        check("tie_second_addr", mem_addr, 64'h8000_0100);
        mem_data_ok = 1'b1;
        mem_rdata   = 64'h5555;
        req_valid   = 2'b00;
        tick();
        mem_data_ok = 1'b0;

        // both valid continuously for four transactions
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            seq_port = (i % 2 == 0);
`else
            seq_port = 1'b1;
`endif
            push_exp(seq_port ? 1 : 0, 64'h100 + 64'(i));
            tick();
            check("seq_grant", {63'd0, grant}, {63'd0, seq_port});
            mem_data_ok = 1'b1;
            mem_rdata   = 64'h100 + 64'(i);
            tick();
            mem_data_ok = 1'b0;
            check("seq_idle", {63'd0, mem_valid}, 64'd0);
        end
        req_valid = 2'b00;
        tick();
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
